// File: rtl/input_debounce_sync.sv
// input_debounce_sync
//   Conditions raw, asynchronous switch/button levels for the all-high detector.
//   Each channel goes through a 2-flop synchroniser. A per-channel counter then
//   accepts a new level only after it has persisted for DEBOUNCE_CYCLES
//   consecutive synchronised cycles. One-cycle edge strobes are produced when a
//   new level is accepted.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   raw_in       [NUM_CH]  raw asynchronous levels
//   db_out       [NUM_CH]  debounced levels (registered)
//   rise_pulse   [NUM_CH]  one-cycle strobe, db_out 0->1
//   fall_pulse   [NUM_CH]  one-cycle strobe, db_out 1->0
//   all_settled  1         registered; no channel had a pending mismatch at the previous edge

// Per-channel debounce counter and strobe generator.
module input_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic synced,
    output logic db,
    output logic rise,
    output logic fall,
    output logic idle
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            db   <= 1'b0;
            rise <= 1'b0;
            fall <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (synced == db) begin
                // any matching cycle abandons a partial count
                cnt <= '0;
            end else if (cnt == LAST) begin
                db   <= synced;
                cnt  <= '0;
                rise <= synced;
                fall <= ~synced;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Channel has nothing in flight: no partial count and no new mismatch.
    assign idle = (cnt == '0) && (synced == db);
endmodule

module input_debounce_sync #(
    parameter int NUM_CH          = 4,
    parameter int DEBOUNCE_CYCLES = 8,
    parameter int CNT_W           = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] raw_in,
    output logic [NUM_CH-1:0] db_out,
    output logic [NUM_CH-1:0] rise_pulse,
    output logic [NUM_CH-1:0] fall_pulse,
    output logic              all_settled
);
    logic [NUM_CH-1:0] s1, s2;
    logic [NUM_CH-1:0] idle;

    // Two-flop synchroniser; only s2 feeds any logic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
        end else begin
            s1 <= raw_in;
            s2 <= s1;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        input_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_ch (
            .clk   (clk),
            .rst_n (rst_n),
            .synced(s2[i]),
            .db    (db_out[i]),
            .rise  (rise_pulse[i]),
            .fall  (fall_pulse[i]),
            .idle  (idle[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) all_settled <= 1'b0;
        else        all_settled <= &idle;
    end
endmodule
